// File: rtl/fmap_stream_serializer_pkg.sv
// Shared types and elaboration helpers for the feature-map stream serializer.
//   fs_state_t       : top-level FSM state (IDLE / STREAM)
//   beats_per_frame(): number of LANES-wide beats in one H x W x C map
//   cnt_w()          : counter width for a 0..n-1 counter (never below 1 bit)
package fmap_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fs_state_t;

  function automatic int beats_per_frame(input int h, input int w, input int c, input int l);
    return (h * w * c) / l;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_stream_serializer_if.sv
// Valid/ready beat link carrying LANES channels of DATA_WIDTH bits per beat.
//   m_valid : beat valid (source)
//   m_ready : sink ready (sink)
//   m_data  : LANES*DATA_WIDTH beat payload, lane 0 in the LSBs (source)
//   m_sol   : first beat of a row (source)
//   m_last  : final beat of the frame (source)
interface fmap_stream_serializer_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 8
);
  logic                          m_valid;
  logic                          m_ready;
  logic [LANES*DATA_WIDTH-1:0]   m_data;
  logic                          m_sol;
  logic                          m_last;

  modport master (output m_valid, output m_data, output m_sol, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_sol, input m_last, output m_ready);
endinterface

// File: rtl/fmap_stream_serializer_beat_counter.sv
// Nested row / column / channel-group position counter for the serializer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   advance_i       : step to the next beat (g fastest, then w, then h; wraps to 0 after last)
//   clear_i         : return to beat 0; takes priority over advance_i
//   h_o, w_o, g_o   : current row, column and channel group
//   first_of_row_o  : current beat is w==0, g==0
//   last_o          : current beat is the final beat of the frame
module fmap_beat_counter
  import fmap_stream_pkg::*;
#(
  parameter int HEIGHT = 7,
  parameter int WIDTH  = 7,
  parameter int GROUPS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      advance_i,
  input  logic                      clear_i,
  output logic [cnt_w(HEIGHT)-1:0]  h_o,
  output logic [cnt_w(WIDTH)-1:0]   w_o,
  output logic [cnt_w(GROUPS)-1:0]  g_o,
  output logic                      first_of_row_o,
  output logic                      last_o
);
  localparam int HW = cnt_w(HEIGHT);
  localparam int WW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GROUPS);
  localparam logic [HW-1:0] H_MAX = HW'(HEIGHT - 1);
  localparam logic [WW-1:0] W_MAX = WW'(WIDTH - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GROUPS - 1);

  logic [HW-1:0] h_q;
  logic [WW-1:0] w_q;
  logic [GW-1:0] g_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      w_q <= '0;
      g_q <= '0;
    end else if (clear_i) begin
      h_q <= '0;
      w_q <= '0;
      g_q <= '0;
    end else if (advance_i) begin
      if (g_q == G_MAX) begin
        g_q <= '0;
        if (w_q == W_MAX) begin
          w_q <= '0;
          h_q <= (h_q == H_MAX) ? '0 : h_q + 1'b1;
        end else begin
          w_q <= w_q + 1'b1;
        end
      end else begin
        g_q <= g_q + 1'b1;
      end
    end
  end

  assign h_o            = h_q;
  assign w_o            = w_q;
  assign g_o            = g_q;
  assign first_of_row_o = (w_q == '0) && (g_q == '0);
  assign last_o         = (h_q == H_MAX) && (w_q == W_MAX) && (g_q == G_MAX);

endmodule

// File: rtl/fmap_stream_serializer.sv
// Transmit side of the feature-map link: snapshots a parallel [H][W][C] map on
// an accepted start and streams it as LANES-channel beats, row -> column -> group.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request snapshot + stream (honoured only when idle and not aborting)
//   abort      : drop the in-flight stream; wins over a same-cycle handshake
//   fmap_in    : parallel map, sampled only on an accepted start
//   busy       : a frame is being streamed
//   done       : one-cycle pulse after the final beat handshake
//   m          : master side of the beat link (valid/ready/data/sol/last)
module fmap_stream_serializer
  import fmap_stream_pkg::*;
#(
  parameter int HEIGHT     = 7,
  parameter int WIDTH      = 7,
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0][DATA_WIDTH-1:0] fmap_in,
  output logic busy,
  output logic done,
  fmap_stream_serializer_if.master m
);
  localparam int GROUPS = CHANNELS / LANES;

  if (CHANNELS % LANES != 0) begin : g_bad_lanes
    $error("fmap_stream_serializer: CHANNELS must be a multiple of LANES");
  end

  fs_state_t state_q;
  logic      done_q;
  logic [HEIGHT-1:0][WIDTH-1:0][CHANNELS-1:0][DATA_WIDTH-1:0] shadow_q;

  logic [cnt_w(HEIGHT)-1:0] h_cnt;
  logic [cnt_w(WIDTH)-1:0]  w_cnt;
  logic [cnt_w(GROUPS)-1:0] g_cnt;
  logic                     first_of_row;
  logic                     last_beat;
  logic                     advance;

  // The link never bubbles inside a frame, so "valid" is exactly "streaming".
  assign busy    = (state_q == STREAM);
  assign advance = busy && m.m_ready && !abort;

  // Abort clears the position unconditionally; in IDLE it is already zero.
  fmap_beat_counter #(
    .HEIGHT (HEIGHT),
    .WIDTH  (WIDTH),
    .GROUPS (GROUPS)
  ) u_beat_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .advance_i      (advance),
    .clear_i        (abort),
    .h_o            (h_cnt),
    .w_o            (w_cnt),
    .g_o            (g_cnt),
    .first_of_row_o (first_of_row),
    .last_o         (last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      // NOTE: the shadow map is reset too, so m_data reads zero out of reset
      // instead of stale contents; it is a register bank, not an inferred RAM.
      shadow_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q  <= STREAM;
            shadow_q <= fmap_in;
          end
        end
        STREAM: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (m.m_ready && last_beat) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane mux: view the current pixel as GROUPS beats, lane 0 = lowest channel.
  logic [GROUPS-1:0][LANES*DATA_WIDTH-1:0] pixel_groups;
  assign pixel_groups = shadow_q[h_cnt][w_cnt];

  assign m.m_data  = pixel_groups[g_cnt];
  assign m.m_valid = busy;
  assign m.m_sol   = busy && first_of_row;
  assign m.m_last  = busy && last_beat;
  assign done      = done_q;

endmodule

// File: tb/tb_fmap_stream_serializer.sv
module tb_fmap_stream_serializer;
  import fmap_stream_pkg::*;

  localparam int H     = 2;
  localparam int W     = 2;
  localparam int C     = 8;
  localparam int L     = 4;
  localparam int DW    = 8;
  localparam int G     = C / L;
  localparam int BEATS = beats_per_frame(H, W, C, L);

  typedef logic [H-1:0][W-1:0][C-1:0][DW-1:0] map_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  map_t fmap  = '0;
  logic busy;
  logic done;

  fmap_stream_serializer_if #(.LANES(L), .DATA_WIDTH(DW)) m_if ();

  fmap_stream_serializer #(
    .HEIGHT(H), .WIDTH(W), .CHANNELS(C), .DATA_WIDTH(DW), .LANES(L)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .fmap_in (fmap),
    .busy    (busy),
    .done    (done),
    .m       (m_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit   mdl_busy = 1'b0;
  bit   mdl_done = 1'b0;
  int   mdl_idx  = 0;
  map_t mdl_cap  = '0;

  // Beat b of a frame: row-major over pixels, channel groups fastest.
  function automatic logic [L*DW-1:0] exp_data(input map_t mp, input int b);
    int hh, ww, gg;
    logic [L*DW-1:0] r;
    hh = b / (W * G);
    ww = (b / G) % W;
    gg = b % G;
    r  = '0;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = mp[hh][ww][gg*L + k];
    return r;
  endfunction

  function automatic logic exp_sol(input int b);
    return ((b % G) == 0) && (((b / G) % W) == 0);
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      mdl_done = 1'b0;
      if (!mdl_busy) begin
        if (start && !abort) begin
          mdl_cap  = fmap;
          mdl_busy = 1'b1;
          mdl_idx  = 0;
        end
      end else if (abort) begin
        mdl_busy = 1'b0;
      end else if (m_if.m_ready) begin
        mdl_idx++;
        if (mdl_idx == BEATS) begin
          mdl_busy = 1'b0;
          mdl_done = 1'b1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    mdl_busy = 1'b0;
    mdl_done = 1'b0;
    mdl_idx  = 0;
  end

  // Handshake statistics for literal expectations.
  int hs_cnt  = 0;
  int sol_cnt = 0;
  int last_at = -1;

  // Single compare process: outputs sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_busy", busy, mdl_busy);
      check("cmp_valid", m_if.m_valid, mdl_busy);
      check("cmp_done", done, mdl_done);
      if (mdl_busy) begin
        check("cmp_data", m_if.m_data, exp_data(mdl_cap, mdl_idx));
        check("cmp_sol", m_if.m_sol, exp_sol(mdl_idx));
        check("cmp_last", m_if.m_last, (mdl_idx == BEATS - 1));
      end
      if (m_if.m_valid && m_if.m_ready && !abort) begin
        if (m_if.m_sol) sol_cnt++;
        if (m_if.m_last) last_at = hs_cnt;
        hs_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic map_t ramp_map();
    map_t r;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        for (int c = 0; c < C; c++) r[h][w][c] = 8'(16*h + 4*w + c);
    return r;
  endfunction

  function automatic map_t fill_map(input logic [DW-1:0] v);
    map_t r;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        for (int c = 0; c < C; c++) r[h][w][c] = v;
    return r;
  endfunction

  function automatic map_t rand_map();
    map_t r;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        for (int c = 0; c < C; c++) r[h][w][c] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    hs_cnt  = 0;
    sol_cnt = 0;
    last_at = -1;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0; 2: random ready + stray starts.
  task automatic run_frame(input int mode, input int abort_at, output int cycles, output bit aborted);
    bit finished;
    cycles   = 0;
    aborted  = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = (i % 3 == 0);
        default: m_if.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) start = ($urandom_range(0, 7) == 0);
      abort = (i == abort_at);
      tick();
      cycles++;
      if (abort) begin
        aborted  = 1'b1;
        finished = 1'b1;
        break;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("frame_timeout", finished, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    bit ab;
    m_if.m_ready = 1'b0;

    // Reset values
    #12;
    check("rst_valid", m_if.m_valid, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_sol",   m_if.m_sol, 1'b0);
    check("rst_last",  m_if.m_last, 1'b0);
    check("rst_data",  m_if.m_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: full-rate frame
    fmap = ramp_map();
    clear_stats();
    pulse_start();
    check("t1_first_data", m_if.m_data, 32'h03020100);
    check("t1_first_sol",  m_if.m_sol, 1'b1);
    run_frame(0, -1, cyc, ab);
    check("t1_cycles", cyc, 8);
    check("t1_beats",  hs_cnt, 8);
    check("t1_last_at", last_at, 7);
    check("t1_done",   done, 1'b1);
    tick();
    check("t1_done_pulse", done, 1'b0);

    // 2: stalls with ready 1,0,0
    clear_stats();
    pulse_start();
    run_frame(1, -1, cyc, ab);
    check("t2_cycles", cyc, 22);
    check("t2_beats",  hs_cnt, 8);
    check("t2_sols",   sol_cnt, 2);
    tick();

    // 3: input changes after capture, stray start while busy
    fmap = ramp_map();
    clear_stats();
    pulse_start();
    fmap  = fill_map(8'h7F);
    start = 1'b1;
    m_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t3_beat1", m_if.m_data, 32'h07060504);
    run_frame(0, -1, cyc, ab);
    check("t3_beats", hs_cnt, 8);
    tick(); tick();
    check("t3_no_restart", busy, 1'b0);

    // 4: abort on beat 3
    fmap = ramp_map();
    clear_stats();
    pulse_start();
    run_frame(0, 3, cyc, ab);
    check("t4_aborted", ab, 1'b1);
    check("t4_valid", m_if.m_valid, 1'b0);
    check("t4_busy",  busy, 1'b0);
    check("t4_beats", hs_cnt, 3);
    tick();
    check("t4_no_done", done, 1'b0);
    clear_stats();
    pulse_start();
    check("t4_restart_data", m_if.m_data, 32'h03020100);
    run_frame(0, -1, cyc, ab);
    check("t4_restart_beats", hs_cnt, 8);
    tick();

    // abort in IDLE, with and without start
    abort = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start", busy, 1'b0);
    tick();

    // 5: back-to-back start in the done cycle
    fmap = ramp_map();
    clear_stats();
    pulse_start();
    run_frame(0, -1, cyc, ab);
    check("t5_in_done_cycle", done, 1'b1);
    clear_stats();
    fmap = fill_map(8'hFF);
    pulse_start();
    check("t5_valid", m_if.m_valid, 1'b1);
    check("t5_data",  m_if.m_data, 32'hFFFFFFFF);
    run_frame(0, -1, cyc, ab);
    check("t5_beats", hs_cnt, 8);
    tick();

    // 6: asynchronous reset on beat 5
    fmap = ramp_map();
    m_if.m_ready = 1'b1;
    pulse_start();
    repeat (5) tick();
    check("t6_pre_valid", m_if.m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_valid", m_if.m_valid, 1'b0);
    check("t6_busy",  busy, 1'b0);
    check("t6_data",  m_if.m_data, 32'h0);
    check("t6_last",  m_if.m_last, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_idle_valid", m_if.m_valid, 1'b0);
    check("t6_idle_busy",  busy, 1'b0);

    // Random frames: random maps, ready, stray starts, occasional aborts
    for (int f = 0; f < 40; f++) begin
      int abort_at;
      fmap = rand_map();
      pulse_start();
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_frame(2, abort_at, cyc, ab);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
